// File: rtl/cache_defs.sv
// Shared data-cache definitions: line/beat geometry and the line-transfer FSM states.
package cache_defs;

    localparam int DCACHE_NO_OF_SETS = 64;
    localparam int LINE_WIDTH        = 128;
    localparam int BEAT_WIDTH        = 32;
    localparam int NUM_BEATS         = LINE_WIDTH / BEAT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FILL_WR,
        EV_RD,
        EV_CAP,
        EV_BEAT
    } xfer_state_e;

endpackage

// File: rtl/dcache_line_xfer.sv
// Moves one cache line between the data RAM and the beat-wide memory bus:
// fill gathers beats into a line and writes it; evict reads a line and streams it out.
module dcache_line_xfer #(
    parameter int LINE_WIDTH = cache_defs::LINE_WIDTH,
    parameter int BEAT_WIDTH = cache_defs::BEAT_WIDTH,
    parameter int ADDR_WIDTH = $clog2(cache_defs::DCACHE_NO_OF_SETS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    input  logic                    cmd_evict,
    input  logic [ADDR_WIDTH-1:0]   cmd_idx,
    output logic                    cmd_ready,
    output logic                    done,
    input  logic                    mem_rvalid,
    input  logic [BEAT_WIDTH-1:0]   mem_rdata,
    output logic                    mem_rready,
    output logic                    mem_wvalid,
    output logic [BEAT_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_wready,
    output logic                    ram_req,
    output logic [LINE_WIDTH/8-1:0] ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [LINE_WIDTH-1:0]   ram_wdata,
    input  logic [LINE_WIDTH-1:0]   ram_rdata
);
    import cache_defs::*;

    localparam int               BEATS     = LINE_WIDTH / BEAT_WIDTH;
    localparam int               CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    xfer_state_e           state, state_nxt;
    logic [CNT_W-1:0]      beat_cnt;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  done_q;
    logic                  cmd_fire, rd_fire, wr_fire, last_beat;

    assign cmd_fire  = cmd_valid && (state == IDLE);
    assign rd_fire   = mem_rvalid && (state == FILL);
    assign wr_fire   = mem_wready && (state == EV_BEAT);
    assign last_beat = (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt  = state;
        cmd_ready  = 1'b0;
        mem_rready = 1'b0;
        mem_wvalid = 1'b0;
        ram_req    = 1'b0;
        ram_wr_en  = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = cmd_evict ? EV_RD : FILL;
            end
            FILL: begin
                mem_rready = 1'b1;
                if (mem_rvalid && last_beat) state_nxt = FILL_WR;
            end
            FILL_WR: begin
                ram_req   = 1'b1;
                ram_wr_en = '1;
                state_nxt = IDLE;
            end
            EV_RD: begin
                ram_req   = 1'b1;
                state_nxt = EV_CAP;
            end
            EV_CAP: state_nxt = EV_BEAT;
            EV_BEAT: begin
                mem_wvalid = 1'b1;
                if (mem_wready && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the line buffer is reset too, so an aborted transfer leaves no stale partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            line_buf <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FILL_WR) || (wr_fire && last_beat);
            if (cmd_fire) idx_q <= cmd_idx;
            if (rd_fire) line_buf[int'(beat_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
            if (state == EV_CAP) line_buf <= ram_rdata;
            // Four handshakes wrap the counter back to 0, ready for the next state entry.
            if (rd_fire || wr_fire) beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    assign done      = done_q;
    assign ram_addr  = idx_q;
    assign ram_wdata = line_buf;
    assign mem_wdata = line_buf[int'(beat_cnt)*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: tb/tb_dcache_line_xfer.sv
// Self-checking bench for dcache_line_xfer: directed and randomized fills/evicts
// compared cycle by cycle against a line/beat model built from the transfer rules.
module tb_dcache_line_xfer;
    localparam int LW = 128;
    localparam int BW = 32;
    localparam int NB = LW / BW;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_evict;
    logic [AW-1:0] cmd_idx;
    logic          cmd_ready, done;
    logic          mem_rvalid, mem_rready;
    logic [BW-1:0] mem_rdata, mem_wdata;
    logic          mem_wvalid, mem_wready;
    logic          ram_req;
    logic [LW/8-1:0] ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [LW-1:0] ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_line_xfer #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_evict(cmd_evict), .cmd_idx(cmd_idx),
        .cmd_ready(cmd_ready), .done(done),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
        .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
        .ram_req(ram_req), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control outputs expected in the current cycle.
    task automatic outs(input string tag, input logic rdy, input logic rrdy, input logic wv,
                        input logic req, input logic wen, input logic dn);
        check({tag, ".cmd_ready"},  cmd_ready,  rdy);
        check({tag, ".mem_rready"}, mem_rready, rrdy);
        check({tag, ".mem_wvalid"}, mem_wvalid, wv);
        check({tag, ".ram_req"},    ram_req,    req);
        check({tag, ".ram_wr_en"},  ram_wr_en,  wen ? {(LW/8){1'b1}} : '0);
        check({tag, ".done"},       done,       dn);
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next();
            outs("idle", 1, 0, 0, 0, 0, 0);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts at an IDLE negedge, ends on the done cycle (so a chained command meets done).
    task automatic do_fill(input logic [AW-1:0] idx, input logic [BW-1:0] beat[NB],
                           input int gap[NB], input bit pulse);
        logic [LW-1:0] line;
        for (int k = 0; k < NB; k++) line[k*BW +: BW] = beat[k];
        check("fill.accept_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_evict = 1'b0; cmd_idx = idx;
        next();
        cmd_valid = 1'b0; cmd_idx = AW'($urandom);
        for (int k = 0; k < NB; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                mem_rvalid = 1'b0; mem_rdata = $urandom;
                if (pulse) begin cmd_valid = 1'b1; cmd_evict = 1'($urandom); end
                outs("fill.gap", 0, 1, 0, 0, 0, 0);
                next();
                cmd_valid = 1'b0;
            end
            mem_rvalid = 1'b1; mem_rdata = beat[k];
            outs("fill.beat", 0, 1, 0, 0, 0, 0);
            next();
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        outs("fill.wr", 0, 0, 0, 1, 1, 0);
        check("fill.wr_addr", ram_addr, idx);
        check("fill.wr_data", ram_wdata, line);
        next();
        outs("fill.done", 1, 0, 0, 0, 0, 1);
    endtask

    task automatic do_evict(input logic [AW-1:0] idx, input logic [LW-1:0] line, input int stall[NB]);
        check("ev.accept_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_evict = 1'b1; cmd_idx = idx;
        next();
        cmd_valid = 1'b0; cmd_idx = AW'($urandom); ram_rdata = rand_line();
        outs("ev.rd", 0, 0, 0, 1, 0, 0);
        check("ev.rd_addr", ram_addr, idx);
        next();
        ram_rdata = line;
        outs("ev.cap", 0, 0, 0, 0, 0, 0);
        next();
        ram_rdata = rand_line();
        for (int k = 0; k < NB; k++) begin
            for (int s = 0; s < stall[k]; s++) begin
                mem_wready = 1'b0;
                outs("ev.stall", 0, 0, 1, 0, 0, 0);
                check("ev.stall_data", mem_wdata, line[k*BW +: BW]);
                next();
            end
            mem_wready = 1'b1;
            outs("ev.beat", 0, 0, 1, 0, 0, 0);
            check("ev.beat_data", mem_wdata, line[k*BW +: BW]);
            next();
            mem_wready = 1'b0;
        end
        outs("ev.done", 1, 0, 0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BW-1:0] b[NB];
        int            z[NB];
        int            g[NB];
        logic [LW-1:0] ln;

        rst = 1'b1; cmd_valid = 1'b0; cmd_evict = 1'b0; cmd_idx = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_wready = 1'b0; ram_rdata = '0;
        z = '{0, 0, 0, 0};

        // Reset state
        next(); next();
        outs("reset", 1, 0, 0, 0, 0, 0);
        check("reset.ram_wdata", ram_wdata, '0);
        check("reset.mem_wdata", mem_wdata, '0);
        check("reset.ram_addr",  ram_addr,  '0);
        rst = 1'b0;
        idle(1);

        // Back-to-back fill at idx 5
        b = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        do_fill(6'd5, b, z, 1'b0);
        check("fill5.line_const", ram_wdata, 128'h44444444_33333333_22222222_11111111);

        // Evict idx 9 issued in the done cycle of the fill
        ln = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        do_evict(6'd9, ln, z);

        // Evict with 3-cycle back-pressure on beat 1
        idle(2);
        g = '{0, 3, 0, 0};
        do_evict(6'd3, ln, g);

        // Fill with an idle cycle between beats and stray commands mid-fill
        idle(1);
        for (int k = 0; k < NB; k++) b[k] = $urandom;
        g = '{0, 1, 1, 1};
        do_fill(6'd7, b, g, 1'b1);

        // Reset after the second fill beat aborts the transfer
        idle(1);
        cmd_valid = 1'b1; cmd_evict = 1'b0; cmd_idx = 6'd4;
        next();
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            outs("abort.beat", 0, 1, 0, 0, 0, 0);
            next();
        end
        mem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        outs("abort.in_reset", 1, 0, 0, 0, 0, 0);
        check("abort.line_cleared", ram_wdata, '0);
        next();
        rst = 1'b0;
        idle(6);
        for (int k = 0; k < NB; k++) b[k] = $urandom;
        do_fill(6'd12, b, z, 1'b0);

        // Randomized mix of fills and evicts
        for (int t = 0; t < 24; t++) begin
            idle($urandom_range(0, 2));
            for (int k = 0; k < NB; k++)
                g[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 1) == 1) begin
                do_evict(AW'($urandom), rand_line(), g);
            end else begin
                for (int k = 0; k < NB; k++) b[k] = $urandom;
                do_fill(AW'($urandom), b, g, 1'($urandom));
            end
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
